// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU controller: FSM states, register map,
// the power-up configuration table and the unpacked sample layout.
package imu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    ID_ISSUE,
    ID_WAIT,
    READY,
    RD_ISSUE,
    RD_WAIT,
    ERROR
  } state_t;

  localparam logic [7:0] WHOAMI_ADDR        = 8'h0F;
  localparam logic [7:0] WHOAMI_DEFAULT     = 8'h6C;
  localparam logic [7:0] BURST_ADDR_DEFAULT = 8'h22;
  localparam int         INIT_LEN           = 3;
  localparam logic [1:0] INIT_LAST          = 2'(INIT_LEN - 1);

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } reg_wr_t;

  typedef struct packed {
    logic signed [15:0] gx;
    logic signed [15:0] gy;
    logic signed [15:0] gz;
    logic signed [15:0] ax;
    logic signed [15:0] ay;
    logic signed [15:0] az;
  } sample_t;

  // Configuration writes issued in order after start: two ODR/range registers, then control.
  function automatic reg_wr_t init_entry(input logic [1:0] idx);
    reg_wr_t e;
    case (idx)
      2'd0:    e = '{addr: 8'h10, data: 8'h60};
      2'd1:    e = '{addr: 8'h11, data: 8'h60};
      default: e = '{addr: 8'h12, data: 8'h44};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/imu_unpack.sv
// Splits the 12-byte burst (byte 0 in the low bits) into six little-endian signed words.
// Purely combinational, no handshake.
module imu_unpack
  import imu_pkg::*;
(
  input  logic [95:0] raw,
  output sample_t     sample
);

  always_comb begin
    sample    = '0;
    sample.gx = raw[15:0];
    sample.gy = raw[31:16];
    sample.gz = raw[47:32];
    sample.ax = raw[63:48];
    sample.ay = raw[79:64];
    sample.az = raw[95:80];
  end

endmodule

// File: rtl/imu_ctrl.sv
// IMU controller: writes the init table, verifies WHO_AM_I, then services ticks with bursts.
// One cycle from tick to burst_enable and from burst_done to sample_valid; busy ticks flag overrun.
module imu_ctrl
  import imu_pkg::*;
#(
  parameter logic [7:0] WHOAMI_VAL = WHOAMI_DEFAULT,
  parameter logic [7:0] BURST_ADDR = BURST_ADDR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  output logic [7:0]         spi_addr,
  output logic [7:0]         spi_wdata,
  output logic               spi_read,
  output logic               spi_enable,
  input  logic               spi_done,
  input  logic [7:0]         spi_rdata,
  output logic [7:0]         burst_addr,
  output logic               burst_enable,
  input  logic               burst_done,
  input  logic [95:0]        burst_rdata,
  output logic signed [15:0] gx,
  output logic signed [15:0] gy,
  output logic signed [15:0] gz,
  output logic signed [15:0] ax,
  output logic signed [15:0] ay,
  output logic signed [15:0] az,
  output logic               sample_valid,
  output logic               ready,
  output logic               error,
  output logic               overrun
);

  state_t     state;
  logic [1:0] idx;
  sample_t    unpacked;
  sample_t    smp;

  imu_unpack u_unpack (
    .raw    (burst_rdata),
    .sample (unpacked)
  );

  assign gx = smp.gx;
  assign gy = smp.gy;
  assign gz = smp.gz;
  assign ax = smp.ax;
  assign ay = smp.ay;
  assign az = smp.az;

  // Enables are set on entry to an *_ISSUE state so they are high exactly while in it;
  // address/data/read are loaded at the same time and left alone until the next issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      spi_addr     <= '0;
      spi_wdata    <= '0;
      spi_read     <= 1'b0;
      spi_enable   <= 1'b0;
      burst_addr   <= '0;
      burst_enable <= 1'b0;
      smp          <= '0;
      sample_valid <= 1'b0;
      ready        <= 1'b0;
      error        <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      spi_enable   <= 1'b0;
      burst_enable <= 1'b0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state                  <= WR_ISSUE;
            idx                    <= '0;
            spi_enable             <= 1'b1;
            spi_read               <= 1'b0;
            {spi_addr, spi_wdata}  <= init_entry(2'd0);
          end
        end
        WR_ISSUE: state <= WR_WAIT;
        WR_WAIT: begin
          if (spi_done) begin
            spi_enable <= 1'b1;
            if (idx == INIT_LAST) begin
              state     <= ID_ISSUE;
              spi_read  <= 1'b1;
              spi_addr  <= WHOAMI_ADDR;
              spi_wdata <= '0;
            end else begin
              state                 <= WR_ISSUE;
              idx                   <= idx + 2'd1;
              {spi_addr, spi_wdata} <= init_entry(idx + 2'd1);
            end
          end
        end
        ID_ISSUE: state <= ID_WAIT;
        ID_WAIT: begin
          if (spi_done) begin
            if (spi_rdata == WHOAMI_VAL) begin
              state <= READY;
              ready <= 1'b1;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end
        READY: begin
          if (tick) begin
            state        <= RD_ISSUE;
            burst_enable <= 1'b1;
            burst_addr   <= BURST_ADDR;
          end
        end
        RD_ISSUE: begin
          state <= RD_WAIT;
          if (tick) overrun <= 1'b1;
        end
        RD_WAIT: begin
          // A tick landing with burst_done is still a drop: no request is queued.
          if (tick) overrun <= 1'b1;
          if (burst_done) begin
            state        <= READY;
            smp          <= unpacked;
            sample_valid <= 1'b1;
          end
        end
        ERROR: begin
          error <= 1'b1;
          ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imu_ctrl.sv
// Scoreboard bench for imu_ctrl: stimulus queues expected SPI/burst/sample/overrun events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_imu_ctrl;

  logic               clk = 1'b0;
  logic               reset, start, tick;
  logic [7:0]         spi_addr, spi_wdata, spi_rdata;
  logic               spi_read, spi_enable, spi_done;
  logic [7:0]         burst_addr;
  logic               burst_enable, burst_done;
  logic [95:0]        burst_rdata;
  logic signed [15:0] gx, gy, gz, ax, ay, az;
  logic               sample_valid, ready, error, overrun;

  always #5 clk = ~clk;

  imu_ctrl #(.WHOAMI_VAL(8'h6C), .BURST_ADDR(8'h22)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .tick         (tick),
    .spi_addr     (spi_addr),
    .spi_wdata    (spi_wdata),
    .spi_read     (spi_read),
    .spi_enable   (spi_enable),
    .spi_done     (spi_done),
    .spi_rdata    (spi_rdata),
    .burst_addr   (burst_addr),
    .burst_enable (burst_enable),
    .burst_done   (burst_done),
    .burst_rdata  (burst_rdata),
    .gx           (gx),
    .gy           (gy),
    .gz           (gz),
    .ax           (ax),
    .ay           (ay),
    .az           (az),
    .sample_valid (sample_valid),
    .ready        (ready),
    .error        (error),
    .overrun      (overrun)
  );

  logic [16:0]  spi_q[$];
  logic [95:0]  sample_q[$];
  int           exp_burst = 0;
  int           exp_ovr   = 0;
  int           errors    = 0;
  int           checks    = 0;
  logic [16:0]  cur_spi   = '0;
  logic [7:0]   whoami_resp = 8'h6C;
  int           spi_cnt   = 0;

  localparam logic [95:0] DATA_A   = 96'h0C0B0A09_08070605_04030201;
  localparam logic [95:0] SAMPLE_A = {16'h0201, 16'h0403, 16'h0605, 16'h0807, 16'h0A09, 16'h0C0B};
  localparam logic [95:0] DATA_B   = 96'h7FFE0001_FFFF8000_ABCD1234;
  localparam logic [95:0] SAMPLE_B = {16'h1234, 16'hABCD, 16'h8000, 16'hFFFF, 16'h0001, 16'h7FFE};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: pulse seen with nothing expected", name);
  endtask

  function automatic logic [127:0] all_outs();
    return {1'b0, spi_addr, spi_wdata, spi_read, spi_enable, burst_addr, burst_enable,
            gx, gy, gz, ax, ay, az, sample_valid, ready, error, overrun};
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (spi_enable) begin
      if (spi_q.size() == 0) unexpected("spi_txn");
      else begin
        cur_spi = spi_q.pop_front();
        chk("spi_txn", {spi_addr, spi_wdata, spi_read}, cur_spi);
      end
    end
    if (spi_done) chk("spi_hold", {spi_addr, spi_wdata, spi_read}, cur_spi);
    if (spi_enable || burst_enable) chk("enable_excl", spi_enable & burst_enable, 0);
    if (burst_enable) begin
      if (exp_burst == 0) unexpected("burst_enable");
      else begin
        exp_burst--;
        chk("burst_addr", burst_addr, 8'h22);
      end
    end
    if (sample_valid) begin
      if (sample_q.size() == 0) unexpected("sample_valid");
      else chk("sample", {gx, gy, gz, ax, ay, az}, sample_q.pop_front());
    end
    if (overrun) begin
      if (exp_ovr == 0) unexpected("overrun");
      else exp_ovr--;
    end
  end

  // Single-byte SPI model: completes each transaction 35 cycles after its enable.
  initial begin
    spi_done  = 1'b0;
    spi_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      spi_done  = 1'b0;
      spi_rdata = '0;
      if (reset) spi_cnt = 0;
      else if (spi_cnt > 0) begin
        spi_cnt--;
        if (spi_cnt == 0) begin
          spi_done  = 1'b1;
          spi_rdata = whoami_resp;
        end
      end else if (spi_enable) spi_cnt = 35;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    spi_q.push_back({8'h10, 8'h60, 1'b0});
    spi_q.push_back({8'h11, 8'h60, 1'b0});
    spi_q.push_back({8'h12, 8'h44, 1'b0});
    spi_q.push_back({8'h0F, 8'h00, 1'b1});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    spi_q.delete();
    sample_q.delete();
    exp_burst = 0;
    exp_ovr   = 0;
    cyc(2);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 1000) begin cyc(1); n++; end
    chk(name, ready, 1'b1);
  endtask

  task automatic wait_error(input string name);
    int n = 0;
    while (!error && n < 1000) begin cyc(1); n++; end
    chk(name, error, 1'b1);
  endtask

  task automatic wait_burst(input string name);
    int n = 0;
    while (!burst_enable && n < 20) begin cyc(1); n++; end
    chk(name, burst_enable, 1'b1);
  endtask

  task automatic check_drained(input string name);
    chk({name, "_spi_q"}, spi_q.size(), 0);
    chk({name, "_sample_q"}, sample_q.size(), 0);
    chk({name, "_burst"}, exp_burst, 0);
    chk({name, "_overrun"}, exp_ovr, 0);
  endtask

  initial begin
    start = 1'b0; tick = 1'b0; burst_done = 1'b0; burst_rdata = '0;
    reset = 1'b1;
    cyc(3);
    chk("reset_outputs", all_outs(), '0);
    reset = 1'b0;
    cyc(3);
    chk("idle_outputs", all_outs(), '0);

    // Normal init
    push_init();
    pulse_start();
    wait_ready("init_ready");
    chk("init_error", error, 1'b0);
    check_drained("init");

    // Burst with a second tick arriving while the first is in flight
    burst_rdata = DATA_A;
    exp_burst = 1;
    exp_ovr   = 1;
    sample_q.push_back(SAMPLE_A);
    pulse_tick();
    wait_burst("burst_a");
    cyc(3);
    pulse_tick();
    cyc(5);
    burst_done = 1'b1;
    cyc(1);
    burst_done = 1'b0;
    cyc(4);
    check_drained("burst_a");
    chk("gx_hold", gx, 16'h0201);
    chk("az_hold", az, 16'h0C0B);
    chk("ready_after_a", ready, 1'b1);

    // Tick coincident with burst_done is dropped
    burst_rdata = DATA_B;
    exp_burst = 1;
    pulse_tick();
    wait_burst("burst_b");
    cyc(4);
    sample_q.push_back(SAMPLE_B);
    exp_ovr = 1;
    burst_done = 1'b1;
    tick = 1'b1;
    cyc(1);
    burst_done = 1'b0;
    tick = 1'b0;
    cyc(10);
    check_drained("coincident");
    chk("ready_after_b", ready, 1'b1);
    exp_burst = 1;
    pulse_tick();
    wait_burst("burst_after_b");
    cyc(3);
    sample_q.push_back(SAMPLE_B);
    burst_done = 1'b1;
    cyc(1);
    burst_done = 1'b0;
    cyc(3);
    check_drained("post_b");

    // Reset while waiting on the first write, then a full restart
    assert_reset();
    reset = 1'b0;
    cyc(1);
    chk("reset_clears_samples", all_outs(), '0);
    push_init();
    pulse_start();
    cyc(10);
    assert_reset();
    chk("midinit_reset_outputs", all_outs(), '0);
    reset = 1'b0;
    cyc(1);
    push_init();
    pulse_start();
    wait_ready("restart_ready");
    check_drained("restart");

    // Wrong WHO_AM_I
    assert_reset();
    reset = 1'b0;
    whoami_resp = 8'h6B;
    cyc(1);
    push_init();
    pulse_start();
    wait_error("id_error");
    chk("id_error_ready", ready, 1'b0);
    pulse_tick();
    cyc(10);
    chk("error_sticky", {error, ready}, 2'b10);
    check_drained("error");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imu_ctrl.md
IMU_CTRL -- requirements
Module: imu_ctrl

Interface
REQ-001 Parameter WHOAMI_VAL, default 8'h6C: expected WHO_AM_I (addr 8'h0F) response.
REQ-002 Parameter BURST_ADDR, default 8'h22: first output register of the 12-byte gyro+accel burst.
REQ-003 clk  in  1  sole clock, all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 start  in  1  pulse; begins init sequence when in IDLE.
REQ-006 tick  in  1  pulse; sample request.
REQ-007 spi_addr, spi_wdata  out  8 each  single-byte SPI address and write data.
REQ-008 spi_read  out  1  1 = read transaction.
REQ-009 spi_enable  out  1  single-byte SPI start pulse.
REQ-010 spi_done  in  1  single-byte SPI completion pulse.
REQ-011 spi_rdata  in  8  single-byte SPI read data, valid with spi_done.
REQ-012 burst_addr  out  8  burst SPI start address; burst_enable out 1 start pulse.
REQ-013 burst_done  in  1  burst completion pulse; burst_rdata  in  96  byte k (k=0 first received) at bits [8k+7:8k].
REQ-014 gx, gy, gz, ax, ay, az  out  16 each  signed two's-complement samples.
REQ-015 sample_valid  out  1  one-cycle pulse when sample outputs update.
REQ-016 ready  out  1  init complete; error  out  1  sticky WHO_AM_I mismatch; overrun  out  1  one-cycle pulse on dropped tick.

Function
REQ-017 States: IDLE, WR_ISSUE, WR_WAIT, ID_ISSUE, ID_WAIT, READY, RD_ISSUE, RD_WAIT, ERROR.
REQ-018 Init table, issued in order: (8'h10,8'h60), (8'h11,8'h60), (8'h12,8'h44); write index 0..2.
REQ-019 IDLE -> WR_ISSUE on start; start ignored in every other state.
REQ-020 WR_ISSUE: spi_enable=1 for exactly one cycle, spi_read=0, addr/wdata from table[index]; -> WR_WAIT.
REQ-021 WR_WAIT: on spi_done, index<2 -> index+1, WR_ISSUE; index==2 -> ID_ISSUE.
REQ-022 ID_ISSUE: one-cycle spi_enable, spi_read=1, spi_addr=8'h0F, spi_wdata=0; -> ID_WAIT.
REQ-023 ID_WAIT: on spi_done, spi_rdata==WHOAMI_VAL -> READY, else -> ERROR.
REQ-024 ERROR is terminal until reset; error=1 in ERROR only, all enables 0.
REQ-025 spi_addr, spi_wdata, spi_read SHALL be registered and held stable from the enable cycle through the spi_done cycle.
REQ-026 READY: tick -> RD_ISSUE; burst_enable asserted the cycle after the tick, for one cycle, burst_addr=BURST_ADDR.
REQ-027 RD_ISSUE -> RD_WAIT; RD_WAIT on burst_done -> READY.
REQ-028 Unpack on burst_done (little-endian pairs): gx={b1,b0}, gy={b3,b2}, gz={b5,b4}, ax={b7,b6}, ay={b9,b8}, az={b11,b10}.
REQ-029 Sample outputs registered; sample_valid=1 in the cycle after burst_done, outputs hold until next burst_done.
REQ-030 tick in RD_ISSUE or RD_WAIT: dropped, overrun pulses next cycle; no queued request.
REQ-031 tick coincident with burst_done: dropped with overrun (returns to READY, not RD_ISSUE).
REQ-032 tick outside READY/RD_* (IDLE, init, ERROR) ignored without overrun.
REQ-033 ready=1 in READY, RD_ISSUE, RD_WAIT only.
REQ-034 spi_done/burst_done arriving in a state not waiting for it SHALL be ignored.
REQ-035 spi_enable and burst_enable never asserted in the same cycle.

Reset
REQ-036 reset: state IDLE, index 0, all outputs 0 including samples, ready, error, enables.
REQ-037 reset mid-transaction aborts immediately; downstream SPI blocks receive the same reset.

Structure
REQ-038 Package imu_pkg: state enum, register address constants, init table, WHO_AM_I default.
REQ-039 Sub-module imu_unpack: combinational 96-bit to six signed 16-bit fields.
REQ-040 Target 150-300 lines RTL.

Verification
REQ-041 start, SPI model acks each transaction after 35 cycles, WHO_AM_I 8'h6C -> writes 10/60, 11/60, 12/44 in order, one ID read, ready=1.
REQ-042 WHO_AM_I returns 8'h6B -> error=1, ready=0, tick produces no burst_enable.
REQ-043 tick in READY, burst_rdata bytes 0..11 = 8'h01..8'h0C -> gx=16'h0201, az=16'h0C0B, sample_valid pulses once.
REQ-044 second tick during RD_WAIT -> overrun pulse, exactly one burst_enable total.
REQ-045 reset asserted in WR_WAIT after 10 cycles -> all outputs 0, next start restarts from table entry 0.
REQ-046 tick coincident with burst_done -> overrun pulse, state READY, no new burst_enable.
